imem_loader: RTL

//  Writer side of the instruction memory: parses an ASCII byte stream in the instruction-file

---
 rtl/imem_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Parses an ASCII byte stream of instruction words (WORD_SIZE characters of '0'/'1', MSB
// first, followed by one separator byte per word) and issues one memory write per word.
// It sits between a byte source (UART or bench) and the instruction memory write port, so
// the core can be programmed at run time.
//
// Parameters:
//   SIZE_WORDS  words to load before reporting done (>= 1)
//   BASE_ADDR   byte address of the first word written
//   STRICT_SEP  1: separator must be 8'h0A, otherwise error; 0: any byte is a separator
//   WORD_SIZE   instruction word width in bits (project-wide word size)
//   ADDR_SIZE   memory address width in bits (project-wide address size)
//
// Ports:
//   clk         clock, all state on posedge
//   rst         asynchronous, active-high reset
//   start       1-cycle pulse, begins a load from IDLE, DONE or ERROR
//   in_valid    byte on in_data is valid
//   in_data     ASCII byte
//   in_ready    loader accepts a byte this cycle (transfer = in_valid & in_ready)
//   mem_we      word write strobe, one cycle per word
//   mem_addr    byte address of the write (BASE_ADDR + 4*word_idx)
//   mem_wdata   assembled word
//   busy        loading (BITS/SEP/WRITE)
//   done        all SIZE_WORDS words written
//   error       malformed stream seen
//   err_char    offending byte, captured on entry to ERROR
//   word_count  words written since the last start

module imem_loader #(
    parameter int unsigned SIZE_WORDS = 17,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned STRICT_SEP = 0,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           err_char,
    output logic [ADDR_SIZE-1:0] word_count
);

    localparam int unsigned BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(WORD_SIZE - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_WORD = ADDR_SIZE'(SIZE_WORDS - 1);
    localparam logic [ADDR_SIZE-1:0] BASE      = ADDR_SIZE'(BASE_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StBits,
        StSep,
        StWrite,
        StDone,
        StError
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [ADDR_SIZE-1:0] word_idx_q, word_idx_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]           err_char_q, err_char_d;
    logic [ADDR_SIZE-1:0] word_count_q, word_count_d;

    logic xfer;
    logic is_bit;

    // Ready is a pure decode of the registered state so it never combinationally
    // depends on in_valid.
    assign in_ready   = (state_q == StBits) || (state_q == StSep);
    assign xfer       = in_valid && in_ready;
    assign is_bit     = (in_data == 8'h30) || (in_data == 8'h31);

    assign mem_we     = (state_q == StWrite);
    assign busy       = (state_q == StBits) || (state_q == StSep) || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StError);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err_char   = err_char_q;
    assign word_count = word_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_idx_q    <= '0;
            word_idx_q   <= '0;
            shift_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_char_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            word_idx_q   <= word_idx_d;
            shift_q      <= shift_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_char_q   <= err_char_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        word_idx_d   = word_idx_q;
        shift_d      = shift_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_char_d   = err_char_q;
        word_count_d = word_count_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StBits;
                    bit_idx_d    = '0;
                    word_idx_d   = '0;
                    shift_d      = '0;
                    word_count_d = '0;
                end
            end

            StBits: begin
                if (xfer) begin
                    if (is_bit) begin
                        // ASCII '0'/'1' differ only in bit 0.
                        shift_d = {shift_q[WORD_SIZE-2:0], in_data[0]};
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_d = '0;
                            state_d   = StSep;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        err_char_d = in_data;
                        state_d    = StError;
                    end
                end
            end

            StSep: begin
                if (xfer) begin
                    if ((STRICT_SEP != 0) && (in_data != 8'h0A)) begin
                        err_char_d = in_data;
                        state_d    = StError;
                    end else begin
                        // Latch the write now so address/data are stable for the whole
                        // WRITE cycle and hold afterwards.
                        mem_addr_d  = BASE + (word_idx_q << 2);
                        mem_wdata_d = shift_q;
                        state_d     = StWrite;
                    end
                end
            end

            StWrite: begin
                word_count_d = word_count_q + 1'b1;
                word_idx_d   = word_idx_q + 1'b1;
                bit_idx_d    = '0;
                state_d      = (word_idx_q == LAST_WORD) ? StDone : StBits;
            end

            StDone, StError: begin
                if (start) begin
                    state_d      = StBits;
                    bit_idx_d    = '0;
                    word_idx_d   = '0;
                    shift_d      = '0;
                    word_count_d = '0;
                    err_char_d   = '0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule
